// File: rtl/seg7_pkg.sv
// Shared constants, enums and helpers for the seven-segment frame decoder.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DOWN = 2'b10,
    STEP_JUMP = 2'b11
  } step_t;

  typedef enum logic [1:0] {
    StIdle,
    StSettle,
    StLocked
  } state_t;

  // {m10, m1, s10, s1} to seconds, truncated to 12 bits.
  function automatic logic [11:0] bcd_to_secs(input logic [15:0] bcd);
    logic [11:0] mins;
    mins = 12'(bcd[15:12]) * 12'd10 + 12'(bcd[11:8]);
    return mins * 12'd60 + 12'(bcd[7:4]) * 12'd10 + 12'(bcd[3:0]);
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational seven-segment pattern to BCD decoder with illegal-pattern flag.
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] bcd,
  output logic       illegal
);

  always_comb begin
    bcd     = 4'd0;
    illegal = 1'b0;
    case (seg)
      SEG_0:   bcd = 4'd0;
      SEG_1:   bcd = 4'd1;
      SEG_2:   bcd = 4'd2;
      SEG_3:   bcd = 4'd3;
      SEG_4:   bcd = 4'd4;
      SEG_5:   bcd = 4'd5;
      SEG_6:   bcd = 4'd6;
      SEG_7:   bcd = 4'd7;
      SEG_8:   bcd = 4'd8;
      SEG_9:   bcd = 4'd9;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_frame_decoder.sv
// Samples a four-digit segment bus, accepts stable frames, decodes them to BCD and
// classifies time steps, blanking, flashing and illegal digit patterns.
module seg7_frame_decoder
  import seg7_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned FLASH_WINDOW  = 64
) (
  input  logic        clk_in,
  input  logic        RESET,
  input  logic [27:0] seg_in,
  output logic [15:0] bcd_out,
  output logic        bcd_valid,
  output logic [1:0]  step_out,
  output logic        range_err,
  output logic [3:0]  digit_err,
  output logic        blank_out,
  output logic        flashing,
  output logic [15:0] frame_count
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES);
  localparam int unsigned WinW = $clog2(FLASH_WINDOW);
  localparam logic [CntW-1:0] CntMax  = CntW'(STABLE_CYCLES - 1);
  localparam logic [WinW-1:0] WinLast = WinW'(FLASH_WINDOW - 1);

  logic [27:0]     s_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  state_t          state_q, state_d;
  logic [WinW-1:0] win_q;
  logic [1:0]      tog_q, tog_sum;
  logic [11:0]     prev_secs_q, new_secs;
  logic            have_prev_q;
  logic            accept, is_blank, is_legal, good, toggle, win_end, range_d;
  logic [15:0]     dec_bcd;
  logic [3:0]      dec_ill;
  step_t           step_d;

  for (genvar i = 0; i < 4; i++) begin : g_digit
    seg7_digit_decode u_dec (
      .seg     (s_q[7*i +: 7]),
      .bcd     (dec_bcd[4*i +: 4]),
      .illegal (dec_ill[i])
    );
  end

  always_comb begin
    if (seg_in != s_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle:   state_d = StSettle;
      StSettle: begin
        // cnt_d only reaches its maximum when seg_in == s_q.
        if (cnt_d == CntMax) begin
          state_d = StLocked;
          accept  = 1'b1;
        end
      end
      StLocked: if (seg_in != s_q) state_d = StSettle;
      default:  state_d = StIdle;
    endcase
  end

  assign is_blank = (s_q == {4{SEG_BLANK}});
  assign is_legal = ~|dec_ill;
  assign good     = accept & ~is_blank & is_legal;
  assign new_secs = bcd_to_secs(dec_bcd);
  assign toggle   = accept & (is_blank != blank_out);
  assign win_end  = (win_q == WinLast);
  assign tog_sum  = (toggle && tog_q != 2'd3) ? tog_q + 2'd1 : tog_q;
  assign range_d  = (dec_bcd[15:12] == 4'd0) || (dec_bcd[15:12] > 4'd4) ||
                    (dec_bcd[7:4] > 4'd5);

  // Widened compares so 0 and 4095 are never treated as neighbours.
  always_comb begin
    step_d = STEP_JUMP;
    if (!have_prev_q) begin
      step_d = STEP_NONE;
    end else if ({1'b0, new_secs} == {1'b0, prev_secs_q} + 13'd1) begin
      step_d = STEP_UP;
    end else if ({1'b0, new_secs} + 13'd1 == {1'b0, prev_secs_q}) begin
      step_d = STEP_DOWN;
    end
  end

  always_ff @(posedge clk_in) begin
    if (RESET) begin
      s_q         <= '0;
      cnt_q       <= '0;
      state_q     <= StIdle;
      win_q       <= '0;
      tog_q       <= '0;
      prev_secs_q <= '0;
      have_prev_q <= 1'b0;
      bcd_out     <= '0;
      bcd_valid   <= 1'b0;
      step_out    <= STEP_NONE;
      range_err   <= 1'b0;
      digit_err   <= '0;
      blank_out   <= 1'b0;
      flashing    <= 1'b0;
      frame_count <= '0;
    end else begin
      s_q       <= seg_in;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      bcd_valid <= good;
      win_q     <= win_q + WinW'(1);
      if (win_end) begin
        flashing <= tog_sum[1];
        tog_q    <= '0;
      end else begin
        tog_q <= tog_sum;
      end
      if (accept) begin
        blank_out <= is_blank;
        if (is_blank) begin
          have_prev_q <= 1'b0;
        end else if (!is_legal) begin
          digit_err <= digit_err | dec_ill;
        end else begin
          bcd_out     <= dec_bcd;
          step_out    <= step_d;
          range_err   <= range_d;
          prev_secs_q <= new_secs;
          have_prev_q <= 1'b1;
          if (frame_count != 16'hFFFF) frame_count <= frame_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_frame_decoder.sv
// Bench for seg7_frame_decoder: directed table, hand sequences and random frames vs a model.
module tb_seg7_frame_decoder;

  localparam int unsigned STABLE = 4;
  localparam int unsigned WIN    = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [27:0] seg = '0;
  logic [15:0] bcd_out;
  logic        bcd_valid;
  logic [1:0]  step_out;
  logic        range_err;
  logic [3:0]  digit_err;
  logic        blank_out;
  logic        flashing;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  seg7_frame_decoder #(
    .STABLE_CYCLES (STABLE),
    .FLASH_WINDOW  (WIN)
  ) dut (
    .clk_in      (clk),
    .RESET       (rst),
    .seg_in      (seg),
    .bcd_out     (bcd_out),
    .bcd_valid   (bcd_valid),
    .step_out    (step_out),
    .range_err   (range_err),
    .digit_err   (digit_err),
    .blank_out   (blank_out),
    .flashing    (flashing),
    .frame_count (frame_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  logic [6:0] codes [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic logic [27:0] frame(input int d3, input int d2, input int d1, input int d0);
    return {codes[d3], codes[d2], codes[d1], codes[d0]};
  endfunction

  function automatic int find_code(input logic [6:0] p);
    for (int i = 0; i < 10; i++) if (codes[i] == p) return i;
    return -1;
  endfunction

  // Reference model: run-length of identical samples, accept when the run reaches STABLE.
  logic [27:0] m_last;
  int          m_run, m_fc, m_prev, m_tog, m_cyc;
  bit          m_have, m_valid, m_blank, m_flash, m_range;
  logic [15:0] m_bcd;
  logic [1:0]  m_step;
  logic [3:0]  m_derr;

  task automatic model_edge(input logic r, input logic [27:0] s);
    int old_run, secs;
    int d[4];
    logic [3:0] ill;
    bit tgl;
    if (r) begin
      m_last = '0; m_run = 1; m_fc = 0; m_prev = 0; m_tog = 0; m_cyc = 0;
      m_have = 0; m_valid = 0; m_blank = 0; m_flash = 0; m_range = 0;
      m_bcd = '0; m_step = 2'b00; m_derr = '0;
      return;
    end
    m_valid = 0;
    tgl = 0;
    old_run = m_run;
    if (s == m_last) begin
      if (m_run < STABLE) m_run++;
    end else begin
      m_last = s;
      m_run = 1;
    end
    if (old_run < STABLE && m_run == STABLE) begin
      ill = '0;
      for (int i = 0; i < 4; i++) begin
        d[i] = find_code(s[7*i +: 7]);
        if (d[i] < 0) ill[i] = 1'b1;
      end
      if (s == '0) begin
        tgl = !m_blank; m_blank = 1; m_have = 0;
      end else if (ill != 0) begin
        tgl = m_blank; m_blank = 0; m_derr = m_derr | ill;
      end else begin
        tgl = m_blank; m_blank = 0;
        secs = ((d[3] * 10 + d[2]) * 60 + d[1] * 10 + d[0]) % 4096;
        if (!m_have) m_step = 2'b00;
        else if (secs == m_prev + 1) m_step = 2'b01;
        else if (secs == m_prev - 1) m_step = 2'b10;
        else m_step = 2'b11;
        m_range = (d[3] < 1 || d[3] > 4 || d[1] > 5);
        m_bcd = {4'(d[3]), 4'(d[2]), 4'(d[1]), 4'(d[0])};
        m_valid = 1;
        if (m_fc < 65535) m_fc++;
        m_prev = secs;
        m_have = 1;
      end
    end
    if (tgl && m_tog < 3) m_tog++;
    if (m_cyc % WIN == WIN - 1) begin
      m_flash = (m_tog >= 2);
      m_tog = 0;
    end
    m_cyc++;
  endtask

  task automatic check_all();
    chk("bcd_out", 32'(bcd_out), 32'(m_bcd));
    chk("bcd_valid", 32'(bcd_valid), 32'(m_valid));
    chk("step_out", 32'(step_out), 32'(m_step));
    chk("range_err", 32'(range_err), 32'(m_range));
    chk("digit_err", 32'(digit_err), 32'(m_derr));
    chk("blank_out", 32'(blank_out), 32'(m_blank));
    chk("flashing", 32'(flashing), 32'(m_flash));
    chk("frame_count", 32'(frame_count), 32'(m_fc));
  endtask

  int pulse_cnt, pulse_at, hold_idx;

  task automatic tick(input logic [27:0] s);
    seg = s;
    @(posedge clk);
    model_edge(rst, s);
    #1;
    check_all();
    if (bcd_valid === 1'b1) begin
      pulse_cnt++;
      pulse_at = hold_idx;
    end
    hold_idx++;
  endtask

  task automatic hold(input logic [27:0] s, input int n);
    pulse_cnt = 0; pulse_at = -1; hold_idx = 0;
    for (int i = 0; i < n; i++) tick(s);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick('0);
    tick('0);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [27:0] seg;
    int          n;
    logic [15:0] bcd;
    logic [1:0]  step;
    logic [3:0]  derr;
    logic        blank;
    logic        rng;
    int          pulses;
  } vec_t;

  vec_t tbl [$];

  function automatic vec_t mk(input logic [27:0] s, input int n, input logic [15:0] b,
                              input logic [1:0] st, input logic [3:0] de, input logic bl,
                              input logic rg, input int p);
    vec_t v;
    v.seg = s; v.n = n; v.bcd = b; v.step = st; v.derr = de;
    v.blank = bl; v.rng = rg; v.pulses = p;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [27:0] s;
    int t, kind, m, sc;

    tbl.push_back(mk(frame(1, 0, 2, 0), 8, 16'h1020, 2'b00, 4'h0, 0, 0, 1));
    tbl.push_back(mk(frame(1, 0, 2, 1), 8, 16'h1021, 2'b01, 4'h0, 0, 0, 1));
    tbl.push_back(mk(frame(1, 0, 2, 0), 8, 16'h1020, 2'b10, 4'h0, 0, 0, 1));
    tbl.push_back(mk(frame(1, 0, 5, 9), 8, 16'h1059, 2'b11, 4'h0, 0, 0, 1));
    tbl.push_back(mk(frame(1, 0, 2, 0), 8, 16'h1020, 2'b11, 4'h0, 0, 0, 1));
    tbl.push_back(mk({codes[1], codes[0], codes[2], 7'h2A}, 2, 16'h1020, 2'b11, 4'h0, 0, 0, 0));
    tbl.push_back(mk(frame(1, 0, 2, 0), 8, 16'h1020, 2'b11, 4'h0, 0, 0, 1));
    tbl.push_back(mk({codes[1], 7'h7E, codes[2], codes[0]}, 6, 16'h1020, 2'b11, 4'h4, 0, 0, 0));
    tbl.push_back(mk(frame(1, 0, 2, 1), 8, 16'h1021, 2'b01, 4'h4, 0, 0, 1));
    tbl.push_back(mk(28'h0, 8, 16'h1021, 2'b01, 4'h4, 1, 0, 0));
    tbl.push_back(mk(frame(1, 2, 3, 4), 8, 16'h1234, 2'b00, 4'h4, 0, 0, 1));
    tbl.push_back(mk(frame(5, 5, 5, 5), 8, 16'h5555, 2'b11, 4'h4, 0, 1, 1));
    tbl.push_back(mk(frame(0, 4, 5, 9), 8, 16'h0459, 2'b11, 4'h4, 0, 1, 1));
    tbl.push_back(mk(frame(0, 5, 0, 0), 8, 16'h0500, 2'b01, 4'h4, 0, 1, 1));
    tbl.push_back(mk(frame(0, 4, 5, 9), 8, 16'h0459, 2'b10, 4'h4, 0, 1, 1));
    tbl.push_back(mk(frame(4, 0, 0, 0), 8, 16'h4000, 2'b11, 4'h4, 0, 0, 1));
    tbl.push_back(mk(frame(1, 0, 6, 0), 8, 16'h1060, 2'b11, 4'h4, 0, 1, 1));

    // Directed table
    do_reset();
    chk("reset bcd_out", 32'(bcd_out), 32'h0);
    chk("reset frame_count", 32'(frame_count), 32'h0);
    for (int i = 0; i < tbl.size(); i++) begin
      hold(tbl[i].seg, tbl[i].n);
      chk($sformatf("vec%0d bcd", i), 32'(bcd_out), 32'(tbl[i].bcd));
      chk($sformatf("vec%0d step", i), 32'(step_out), 32'(tbl[i].step));
      chk($sformatf("vec%0d derr", i), 32'(digit_err), 32'(tbl[i].derr));
      chk($sformatf("vec%0d blank", i), 32'(blank_out), 32'(tbl[i].blank));
      chk($sformatf("vec%0d range", i), 32'(range_err), 32'(tbl[i].rng));
      chk($sformatf("vec%0d pulses", i), 32'(pulse_cnt), 32'(tbl[i].pulses));
      if (tbl[i].pulses == 1) chk($sformatf("vec%0d pulse_at", i), 32'(pulse_at), 32'd3);
      if (i == 0) chk("first frame_count", 32'(frame_count), 32'd1);
    end

    // Blank / 5555 alternation for three windows, then steady
    do_reset();
    for (int k = 0; k < 24; k++) begin
      hold((k % 2 == 0) ? 28'h0 : frame(5, 5, 5, 5), 8);
      chk($sformatf("flash seg%0d blank", k), 32'(blank_out), 32'((k % 2 == 0) ? 1 : 0));
      if (k == 7) chk("flash after window 1", 32'(flashing), 32'd1);
    end
    chk("flash after window 3", 32'(flashing), 32'd1);
    chk("flash range_err", 32'(range_err), 32'd1);
    chk("flash frame_count", 32'(frame_count), 32'd12);
    chk("flash step", 32'(step_out), 32'd0);
    hold(frame(5, 5, 5, 5), 64);
    chk("flash cleared", 32'(flashing), 32'd0);

    // Reset landing on the acceptance edge
    do_reset();
    hold(frame(1, 0, 2, 0), 3);
    rst = 1'b1;
    tick(frame(1, 0, 2, 0));
    chk("rst-accept bcd_valid", 32'(bcd_valid), 32'd0);
    chk("rst-accept bcd_out", 32'(bcd_out), 32'd0);
    chk("rst-accept frame_count", 32'(frame_count), 32'd0);
    chk("rst-accept step", 32'(step_out), 32'd0);
    rst = 1'b0;
    hold(frame(1, 0, 2, 0), 6);
    chk("post-rst pulses", 32'(pulse_cnt), 32'd1);
    chk("post-rst frame_count", 32'(frame_count), 32'd1);

    // Random frames against the model
    do_reset();
    t = 620;
    for (int k = 0; k < 400; k++) begin
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        s = '0;
      end else if (kind == 1) begin
        s = 28'($urandom);
      end else begin
        if (kind < 5) t = t + 1;
        else if (kind < 8 && t > 0) t = t - 1;
        else t = int'($urandom_range(0, 5999));
        if (t > 5999) t = 0;
        m = t / 60;
        sc = t % 60;
        s = frame(m / 10, m % 10, sc / 10, sc % 10);
      end
      hold(s, int'($urandom_range(1, 10)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
